// File: rtl/core_ctrl_fsm_pkg.sv
// Shared types and encodings for the RV32 multi-cycle control sequencer.
package core_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    WAIT_IMEM = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    WB        = 3'd4,
    HALT      = 3'd5
  } ctrl_state_t;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_HOLD   = 2'b10;
  localparam logic [1:0] PC_RESET  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/core_ctrl_fsm_branch_cmp.sv
// Branch condition evaluator: decoded branch flags plus operands -> taken.
module core_ctrl_fsm_branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic            is_beq,
  input  logic            is_bne,
  input  logic            is_blt,
  input  logic            is_bge,
  input  logic            is_bltu,
  input  logic            is_bgeu,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  always_comb begin
    eq    = (rs1_data == rs2_data);
    lt_s  = ($signed(rs1_data) < $signed(rs2_data));
    lt_u  = (rs1_data < rs2_data);
    taken = (is_beq  &  eq)   | (is_bne  & ~eq)   |
            (is_blt  &  lt_s) | (is_bge  & ~lt_s) |
            (is_bltu &  lt_u) | (is_bgeu & ~lt_u);
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with branch resolution,
// illegal-opcode and fetch-timeout halt, and a retired-instruction counter.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int IMEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_en,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            ir_load,
  input  logic            is_add,
  input  logic            is_addi,
  input  logic            is_beq,
  input  logic            is_bne,
  input  logic            is_blt,
  input  logic            is_bge,
  input  logic            is_bltu,
  input  logic            is_bgeu,
  input  logic            incorrect,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [1:0]      pc_choice,
  output logic            rf_wr_en,
  output logic            retire,
  output logic [XLEN-1:0] instret,
  output logic            halted,
  output logic [1:0]      err_code,
  output logic [2:0]      fsm_state
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

  ctrl_state_t     state;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      err_q;
  logic [XLEN-1:0] instret_q;
  logic [7:0]      op_vec;
  logic            op_valid;
  logic            is_branch;
  logic            taken;

  assign op_vec    = {is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu};
  assign op_valid  = $onehot(op_vec) && !incorrect;
  assign is_branch = |op_vec[5:0];

  core_ctrl_fsm_branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .is_beq   (is_beq),
    .is_bne   (is_bne),
    .is_blt   (is_blt),
    .is_bge   (is_bge),
    .is_bltu  (is_bltu),
    .is_bgeu  (is_bgeu),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      err_q     <= ERR_NONE;
      instret_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (run_en) state <= imem_ack ? DECODE : WAIT_IMEM;
        end
        WAIT_IMEM: begin
          // An ack arriving in the final allowed cycle still counts as a fetch.
          if (imem_ack) begin
            state    <= DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state    <= HALT;
            err_q    <= ERR_TIMEOUT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          if (op_valid) begin
            state <= EXEC;
          end else begin
            state <= HALT;
            err_q <= ERR_ILLEGAL;
          end
        end
        EXEC: begin
          if (is_branch) begin
            state     <= FETCH;
            instret_q <= instret_q + 1'b1;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          state     <= FETCH;
          instret_q <= instret_q + 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Strobes are decoded from state; reset overrides everything with PC_RESET.
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    pc_choice = PC_HOLD;
    rf_wr_en  = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      pc_choice = PC_RESET;
    end else begin
      case (state)
        FETCH: begin
          imem_req = run_en;
          ir_load  = run_en & imem_ack;
        end
        WAIT_IMEM: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        EXEC: begin
          if (is_branch) begin
            pc_choice = taken ? PC_BRANCH : PC_INC;
            retire    = 1'b1;
          end
        end
        WB: begin
          pc_choice = PC_INC;
          rf_wr_en  = 1'b1;
          retire    = 1'b1;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instret   = instret_q;
  assign err_code  = err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: scoreboard of retire/halt events plus
// directed checks of reset, latency, state trace and counter wrap.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  localparam int W = 38;
  localparam logic [7:0] OP_ADD  = 8'h80;
  localparam logic [7:0] OP_ADDI = 8'h40;
  localparam logic [7:0] OP_BEQ  = 8'h20;
  localparam logic [7:0] OP_BNE  = 8'h10;
  localparam logic [7:0] OP_BLT  = 8'h08;
  localparam logic [7:0] OP_BGE  = 8'h04;
  localparam logic [7:0] OP_BLTU = 8'h02;
  localparam logic [7:0] OP_BGEU = 8'h01;

  // clock / reset / stimulus signals
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run_en, imem_ack, incorrect, s_run_en;
  logic [7:0]  ops;
  logic [31:0] rs1, rs2;

  logic        imem_req, ir_load, rf_wr_en, retire, halted;
  logic [1:0]  pc_choice, err_code;
  logic [31:0] instret;
  logic [2:0]  fsm_state;

  logic        s_imem_req, s_ir_load, s_rf_wr_en, s_retire, s_halted;
  logic [1:0]  s_pc_choice, s_err_code;
  logic [3:0]  s_instret;
  logic [2:0]  s_fsm_state;

  core_ctrl_fsm #(.XLEN(32), .IMEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_load(ir_load), .is_add(ops[7]), .is_addi(ops[6]), .is_beq(ops[5]), .is_bne(ops[4]),
    .is_blt(ops[3]), .is_bge(ops[2]), .is_bltu(ops[1]), .is_bgeu(ops[0]),
    .incorrect(incorrect), .rs1_data(rs1), .rs2_data(rs2), .pc_choice(pc_choice),
    .rf_wr_en(rf_wr_en), .retire(retire), .instret(instret), .halted(halted),
    .err_code(err_code), .fsm_state(fsm_state)
  );

  core_ctrl_fsm #(.XLEN(4), .IMEM_TIMEOUT(4)) dut_small (
    .clk(clk), .reset(reset), .run_en(s_run_en), .imem_req(s_imem_req), .imem_ack(imem_ack),
    .ir_load(s_ir_load), .is_add(ops[7]), .is_addi(ops[6]), .is_beq(ops[5]), .is_bne(ops[4]),
    .is_blt(ops[3]), .is_bge(ops[2]), .is_bltu(ops[1]), .is_bgeu(ops[0]),
    .incorrect(incorrect), .rs1_data(rs1[3:0]), .rs2_data(rs2[3:0]), .pc_choice(s_pc_choice),
    .rf_wr_en(s_rf_wr_en), .retire(s_retire), .instret(s_instret), .halted(s_halted),
    .err_code(s_err_code), .fsm_state(s_fsm_state)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] model_instret;
  logic        halted_d = 1'b0;
  logic [3:0]  trace[$];
  int          lat;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic exp_retire(input logic [1:0] pc);
    exp_q.push_back({1'b0, pc, (pc == PC_INC && ops[7:6] != 2'b00), ERR_NONE, model_instret});
    model_instret++;
  endtask

  task automatic exp_halt(input logic [1:0] err);
    exp_q.push_back({1'b1, PC_HOLD, 1'b0, err, model_instret});
  endtask

  // monitor: every retire pulse or halt entry is popped and compared
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (!reset && (retire || (halted && !halted_d))) begin
      obs = {halted, pc_choice, rf_wr_en, err_code, instret};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%0h", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL event got=%0h exp=%0h", obs, e);
        end
      end
    end
    halted_d = halted;
  end

  // driver: called at posedge+1 with the DUT idle in FETCH
  task automatic issue(input logic [7:0] op, input logic bad, input logic [31:0] a,
                       input logic [31:0] b, input int nwait, output int cycles);
    int  cyc;
    bit  done;
    ops = op; incorrect = bad; rs1 = a; rs2 = b;
    run_en = 1'b1; imem_ack = (nwait == 0);
    cyc = 0; done = 0;
    trace.delete();
    while (!done && cyc < 40) begin
      @(negedge clk);
      trace.push_back({ir_load, fsm_state});
      if (retire || halted) done = 1;
      @(posedge clk); #1;
      cyc++;
      run_en = 1'b0;
      imem_ack = (cyc == nwait);
    end
    imem_ack = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL driver_timeout got=%0d exp=<40", cyc);
    end
    cycles = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1; run_en = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_instret = '0;
    @(negedge clk);
    chk("post_reset", {fsm_state, instret, halted, err_code}, {FETCH, 32'd0, 1'b0, ERR_NONE});
    @(posedge clk); #1;
  endtask

  task automatic halt_hold(input logic [1:0] err);
    run_en = 1'b1; imem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_hold", {halted, pc_choice, imem_req, ir_load, retire, err_code},
          {1'b1, PC_HOLD, 1'b0, 1'b0, 1'b0, err});
      @(posedge clk); #1;
    end
    run_en = 1'b0; imem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b1; imem_ack = 1'b1; ops = OP_ADD; incorrect = 1'b0;
    rs1 = '0; rs2 = '0; s_run_en = 1'b0; model_instret = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_strobes", {pc_choice, imem_req, ir_load, rf_wr_en, retire, halted},
          {PC_RESET, 5'b0});
      @(posedge clk);
    end
    #1;
    reset = 1'b0; run_en = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("reset_state", {fsm_state, instret, halted, err_code}, {FETCH, 32'd0, 1'b0, ERR_NONE});
    @(posedge clk); #1;

    // add, zero-wait fetch: F,D,E,W
    ops = OP_ADD; exp_retire(PC_INC);
    issue(OP_ADD, 1'b0, 32'd1, 32'd2, 0, lat);
    chk("add_latency", lat, 4);
    chk("add_trace", {trace[0], trace[1], trace[2], trace[3]},
        {1'b1, FETCH, 1'b0, DECODE, 1'b0, EXEC, 1'b0, WB});
    @(negedge clk);
    chk("instret_one", instret, 32'd1);
    @(posedge clk); #1;

    ops = OP_ADDI; exp_retire(PC_INC);
    issue(OP_ADDI, 1'b0, 32'd3, 32'd4, 2, lat);
    chk("addi_wait2_latency", lat, 6);

    // branches with hand-computed outcomes
    ops = OP_BEQ;  exp_retire(PC_BRANCH); issue(OP_BEQ, 1'b0, 32'h5, 32'h5, 0, lat);
    chk("beq_latency", lat, 3);
    ops = OP_BEQ;  exp_retire(PC_INC);    issue(OP_BEQ,  1'b0, 32'h5, 32'h6, 0, lat);
    ops = OP_BNE;  exp_retire(PC_BRANCH); issue(OP_BNE,  1'b0, 32'h5, 32'h6, 0, lat);
    ops = OP_BLT;  exp_retire(PC_BRANCH); issue(OP_BLT,  1'b0, 32'hFFFF_FFFF, 32'h1, 0, lat);
    ops = OP_BLTU; exp_retire(PC_INC);    issue(OP_BLTU, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, lat);
    ops = OP_BGE;  exp_retire(PC_INC);    issue(OP_BGE,  1'b0, 32'hFFFF_FFFF, 32'h1, 0, lat);
    ops = OP_BGEU; exp_retire(PC_BRANCH); issue(OP_BGEU, 1'b0, 32'hFFFF_FFFF, 32'h1, 1, lat);
    chk("bgeu_wait1_latency", lat, 4);
    ops = OP_BGE;  exp_retire(PC_BRANCH); issue(OP_BGE,  1'b0, 32'h7, 32'h7, 0, lat);
    ops = OP_BLTU; exp_retire(PC_BRANCH); issue(OP_BLTU, 1'b0, 32'h1, 32'hFFFF_FFFF, 0, lat);

    // ack in the last allowed wait cycle: no error
    ops = OP_ADD; exp_retire(PC_INC);
    issue(OP_ADD, 1'b0, 32'd0, 32'd0, 4, lat);
    chk("ack_at_limit_latency", lat, 8);

    // fetch timeout
    exp_halt(ERR_TIMEOUT);
    issue(OP_ADD, 1'b0, 32'd0, 32'd0, 99, lat);
    chk("timeout_latency", lat, 6);
    halt_hold(ERR_TIMEOUT);
    do_reset();

    // illegal encodings
    exp_halt(ERR_ILLEGAL);
    issue(OP_ADD, 1'b1, 32'd0, 32'd0, 0, lat);
    chk("illegal_latency", lat, 3);
    halt_hold(ERR_ILLEGAL);
    do_reset();
    exp_halt(ERR_ILLEGAL);
    issue(OP_ADD | OP_BEQ, 1'b0, 32'd0, 32'd0, 0, lat);
    halt_hold(ERR_ILLEGAL);
    do_reset();
    exp_halt(ERR_ILLEGAL);
    issue(8'h00, 1'b0, 32'd0, 32'd0, 0, lat);
    do_reset();

    // reset arriving in EXEC of a taken branch
    ops = OP_ADD; exp_retire(PC_INC);
    issue(OP_ADD, 1'b0, 32'd0, 32'd0, 0, lat);
    ops = OP_BEQ; rs1 = 32'h9; rs2 = 32'h9; run_en = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    run_en = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_exec", {fsm_state, pc_choice, retire, instret}, {EXEC, PC_RESET, 1'b0, 32'd1});
    @(posedge clk); #1;
    reset = 1'b0; model_instret = '0;
    @(negedge clk);
    chk("after_exec_reset", {fsm_state, instret, halted}, {FETCH, 32'd0, 1'b0});
    @(posedge clk); #1;

    // instret wrap on the 4-bit instance
    ops = OP_ADD; incorrect = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_run_en = 1'b1; imem_ack = 1'b1;
      @(posedge clk); #1;
      s_run_en = 1'b0; imem_ack = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      if (i == 14) chk("small_instret_max", s_instret, 4'hF);
    end
    chk("small_instret_wrap", s_instret, 4'h0);

    repeat (2) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
